mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port memory between an
// instruction-fetch port (i_*) and a load/store data port (d_*).
//
// Ports
//   clk1, rst            rising-edge clock, synchronous active-high reset
//   i_req/i_addr         fetch request;  i_ack/i_rdata one-cycle completion
//   d_req/d_we/d_addr/   load/store request; d_ack/d_rdata one-cycle
//   d_wdata              completion (d_rdata is 0 for stores)
//   m_en/m_we/m_addr/    memory strobe and write data; m_rdata arrives the
//   m_wdata/m_rdata      cycle after m_en is sampled
//   halt                 blocks new grants, in-flight access still finishes
//   err                  out-of-range pulse, coincident with the ack
//   busy/owner           access in flight / who owns it (0=fetch, 1=data)
//
// Each access walks IDLE -> ISSUE -> RESP -> IDLE. The ack is registered on
// the RESP->IDLE edge, so it is visible in the cycle after that edge while
// the FSM is already back in IDLE; a request still high at the end of that
// ack cycle is granted on that edge, giving one access per three cycles.
module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int DEPTH        = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          halt,
    output logic          err,
    output logic          busy,
    output logic          owner
);

    localparam int            SW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT   = SW'(STARVE_LIMIT);
    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic          oor_q, oor_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          m_en_q, m_en_d;
    logic          m_we_q, m_we_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          err_q, err_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic          grant_data;
    logic [AW-1:0] sel_addr;
    logic          sel_oor;

    always_comb begin
        // Data wins ties until fetch has lost STARVE_LIMIT contested rounds.
        grant_data = d_req && (!i_req || (starve_q != LIMIT));
        sel_addr   = grant_data ? d_addr : i_addr;
        sel_oor    = ({1'b0, sel_addr} >= DEPTH_W);

        state_d   = state_q;
        starve_d  = starve_q;
        owner_d   = owner_q;
        we_d      = we_q;
        oor_d     = oor_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        m_en_d    = 1'b0;
        m_we_d    = 1'b0;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        err_d     = 1'b0;
        i_rdata_d = '0;
        d_rdata_d = '0;

        unique case (state_q)
            IDLE: begin
                if (!halt && (i_req || d_req)) begin
                    state_d = ISSUE;
                    owner_d = grant_data;
                    we_d    = grant_data && d_we;
                    oor_d   = sel_oor;
                    addr_d  = sel_addr;
                    wdata_d = grant_data ? d_wdata : '0;
                    // Strobe is registered here so it is high exactly in ISSUE.
                    m_en_d  = !sel_oor;
                    m_we_d  = !sel_oor && grant_data && d_we;
                    if (!grant_data)
                        starve_d = '0;
                    else if (i_req && (starve_q != LIMIT))
                        starve_d = starve_q + SW'(1);
                end
            end
            ISSUE: state_d = RESP;
            RESP: begin
                // m_rdata is valid now; capture it into the owner's ack.
                state_d = IDLE;
                err_d   = oor_q;
                if (owner_q) begin
                    d_ack_d = 1'b1;
                    if (!we_q && !oor_q) d_rdata_d = m_rdata;
                end else begin
                    i_ack_d = 1'b1;
                    if (!oor_q) i_rdata_d = m_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            oor_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            oor_q     <= oor_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // The memory samples the strobe on the same edge that samples rst, so
    // the strobe is masked by rst to keep a reset during ISSUE from writing.
    assign m_en    = m_en_q && !rst;
    assign m_we    = m_we_q && !rst;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign i_ack   = i_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_ack   = d_ack_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;
    assign busy    = (state_q != IDLE);
    assign owner   = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: small memory (DEPTH=16, AW=8), a behavioural
// SRAM, and a transaction-level reference model (arbitration rule with an
// integer starve counter plus a word array for memory contents).
module tb_mem_arbiter;
    localparam int AW = 8, DW = 32, DEPTH = 16, SL = 4;

    logic          clk1 = 1'b0, rst = 1'b1;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, halt = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          i_ack, d_ack, m_en, m_we, err, busy, owner;
    logic [DW-1:0] i_rdata, d_rdata, m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic [AW-1:0] m_addr;

    mem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .STARVE_LIMIT(SL)) dut (
        .clk1(clk1), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .halt(halt), .err(err), .busy(busy), .owner(owner)
    );

    always #5 clk1 = ~clk1;

    int checks = 0, failures = 0;
    int we_cnt = 0;
    logic both_ack = 1'b0;
    logic preload = 1'b0;
    logic [DW-1:0] sram    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    int starve_ref = 0;

    // Behavioural synchronous SRAM (read-first).
    always @(posedge clk1) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= ref_mem[i];
        end else if (m_en === 1'b1) begin
            if (m_we) sram[m_addr[3:0]] <= m_wdata;
            m_rdata <= sram[m_addr[3:0]];
        end
    end
    always @(posedge clk1) if (m_en === 1'b1 && m_we === 1'b1) we_cnt <= we_cnt + 1;
    always @(negedge clk1) if (i_ack === 1'b1 && d_ack === 1'b1) both_ack <= 1'b1;

    // Reference model: who wins one arbitration round.
    function automatic bit model_pick(input bit ir, input bit dr);
        bit d;
        d = dr && (!ir || starve_ref != SL);
        if (!d) starve_ref = 0;
        else if (ir && starve_ref < SL) starve_ref++;
        return d;
    endfunction

    // Reference model: result of one access, updates the word array.
    function automatic logic [DW-1:0] model_access(input logic [AW-1:0] a, input bit we,
                                                   input logic [DW-1:0] wd);
        int idx;
        idx = int'(a);
        if (idx >= DEPTH) return '0;
        if (we) begin
            ref_mem[idx] = wd;
            return '0;
        end
        return ref_mem[idx];
    endfunction

    typedef struct {
        logic busy1, owner1, m_en1, m_we1;
        logic [AW-1:0] m_addr1;
        logic [DW-1:0] m_wdata1;
        logic early_ack, stray_rdata;
        logic i_ack, d_ack, err, busy3;
        logic [DW-1:0] i_rdata, d_rdata;
    } obs_t;

    // Observe one access whose request is set up at the current negedge:
    // ISSUE cycle, RESP cycle, then the ack cycle.
    task automatic run3(output obs_t o);
        @(posedge clk1); @(negedge clk1);
        o.busy1 = busy; o.owner1 = owner; o.m_en1 = m_en; o.m_we1 = m_we;
        o.m_addr1 = m_addr; o.m_wdata1 = m_wdata;
        o.early_ack = i_ack | d_ack;
        o.stray_rdata = (i_rdata != '0) || (d_rdata != '0);
        @(posedge clk1); @(negedge clk1);
        o.early_ack = o.early_ack | i_ack | d_ack;
        o.stray_rdata = o.stray_rdata || (i_rdata != '0) || (d_rdata != '0);
        @(posedge clk1); @(negedge clk1);
        o.i_ack = i_ack; o.d_ack = d_ack; o.err = err; o.busy3 = busy;
        o.i_rdata = i_rdata; o.d_rdata = d_rdata;
    endtask

    task automatic test_reset();
        obs_t o;
        logic [DW-1:0] exp;
        rst = 1'b1; i_req = 1'b1; i_addr = 8'd5;
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        checks++;
        if ({m_en, m_we, i_ack, d_ack, err, busy, owner} !== 7'b0 || m_addr !== '0 || m_wdata !== '0
            || i_rdata !== '0 || d_rdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b addr=%0h exp=0", {m_en, m_we, i_ack, d_ack, err, busy, owner}, m_addr);
        end
        starve_ref = 0;
        rst = 1'b0;
        void'(model_pick(1'b1, 1'b0));
        exp = model_access(8'd5, 1'b0, '0);
        run3(o);
        i_req = 1'b0;
        checks++;
        if ({o.busy1, o.owner1, o.m_en1, o.m_we1} !== 4'b1010) begin
            failures++; $display("FAIL fetch_issue got=%b exp=1010", {o.busy1, o.owner1, o.m_en1, o.m_we1});
        end
        checks++;
        if (o.m_addr1 !== 8'd5) begin failures++; $display("FAIL fetch_maddr got=%0h exp=5", o.m_addr1); end
        checks++;
        if ({o.i_ack, o.d_ack, o.err, o.early_ack, o.busy3} !== 5'b10000) begin
            failures++; $display("FAIL fetch_ack got=%b exp=10000", {o.i_ack, o.d_ack, o.err, o.early_ack, o.busy3});
        end
        checks++;
        if (o.i_rdata !== 32'h2801000a || o.i_rdata !== exp) begin
            failures++; $display("FAIL fetch_rdata got=%h exp=2801000a", o.i_rdata);
        end
    endtask

    task automatic test_store_load();
        obs_t o;
        logic [DW-1:0] exp;
        int w0;
        w0 = we_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'd8; d_wdata = 32'hfc000000;
        void'(model_pick(1'b0, 1'b1));
        void'(model_access(8'd8, 1'b1, 32'hfc000000));
        run3(o);
        checks++;
        if ({o.busy1, o.owner1, o.m_en1, o.m_we1} !== 4'b1111 || o.m_addr1 !== 8'd8 || o.m_wdata1 !== 32'hfc000000) begin
            failures++; $display("FAIL store_issue got=%b addr=%0h wd=%h", {o.busy1, o.owner1, o.m_en1, o.m_we1}, o.m_addr1, o.m_wdata1);
        end
        checks++;
        if ({o.i_ack, o.d_ack, o.err} !== 3'b010 || o.d_rdata !== '0) begin
            failures++; $display("FAIL store_ack got=%b rdata=%h exp=010/0", {o.i_ack, o.d_ack, o.err}, o.d_rdata);
        end
        d_we = 1'b0;
        void'(model_pick(1'b0, 1'b1));
        exp = model_access(8'd8, 1'b0, '0);
        run3(o);
        d_req = 1'b0;
        checks++;
        if (o.d_ack !== 1'b1 || o.m_we1 !== 1'b0 || o.d_rdata !== 32'hfc000000 || o.d_rdata !== exp) begin
            failures++; $display("FAIL load_back got=%h ack=%b exp=fc000000", o.d_rdata, o.d_ack);
        end
        checks++;
        if (we_cnt - w0 != 1) begin failures++; $display("FAIL store_we_pulses got=%0d exp=1", we_cnt - w0); end
    endtask

    task automatic test_out_of_range();
        obs_t o;
        d_req = 1'b1; d_we = 1'b1; d_addr = AW'(DEPTH); d_wdata = $urandom;
        void'(model_pick(1'b0, 1'b1));
        run3(o);
        d_req = 1'b0;
        checks++;
        if ({o.m_en1, o.m_we1, o.d_ack, o.err, o.i_ack} !== 5'b00110 || o.d_rdata !== '0) begin
            failures++; $display("FAIL oor_store got=%b rdata=%h exp=00110/0", {o.m_en1, o.m_we1, o.d_ack, o.err, o.i_ack}, o.d_rdata);
        end
        i_req = 1'b1; i_addr = 8'd200;
        void'(model_pick(1'b1, 1'b0));
        run3(o);
        i_req = 1'b0;
        checks++;
        if ({o.m_en1, o.i_ack, o.err, o.d_ack} !== 4'b0110 || o.i_rdata !== '0) begin
            failures++; $display("FAIL oor_fetch got=%b rdata=%h exp=0110/0", {o.m_en1, o.i_ack, o.err, o.d_ack}, o.i_rdata);
        end
    endtask

    task automatic test_latch();
        obs_t o;
        logic [DW-1:0] w, exp;
        w = $urandom;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'd9; d_wdata = w;
        void'(model_pick(1'b0, 1'b1));
        void'(model_access(8'd9, 1'b1, w));
        @(posedge clk1); @(negedge clk1);
        checks++;
        if (m_addr !== 8'd9 || m_wdata !== w || m_we !== 1'b1) begin
            failures++; $display("FAIL latch_issue got=%0h/%h/%b exp=9/%h/1", m_addr, m_wdata, m_we, w);
        end
        d_addr = 8'd10; d_wdata = ~w; d_we = 1'b0; d_req = 1'b0;
        @(posedge clk1); @(negedge clk1);
        @(posedge clk1); @(negedge clk1);
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== '0) begin failures++; $display("FAIL latch_ack got=%b/%h exp=1/0", d_ack, d_rdata); end
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'd9;
        void'(model_pick(1'b0, 1'b1));
        exp = model_access(8'd9, 1'b0, '0);
        run3(o);
        checks++;
        if (o.d_rdata !== exp) begin failures++; $display("FAIL latch_load9 got=%h exp=%h", o.d_rdata, exp); end
        d_addr = 8'd10;
        void'(model_pick(1'b0, 1'b1));
        exp = model_access(8'd10, 1'b0, '0);
        run3(o);
        d_req = 1'b0;
        checks++;
        if (o.d_rdata !== exp) begin failures++; $display("FAIL latch_load10 got=%h exp=%h", o.d_rdata, exp); end
    endtask

    task automatic test_contention(input int n, input logic [9:0] pat);
        obs_t o;
        logic [DW-1:0] exp, got, other;
        logic [9:0] seq;
        bit dw;
        seq = '0;
        i_req = 1'b1; i_addr = AW'($urandom_range(0, DEPTH-1));
        d_req = 1'b1; d_we = 1'b0; d_addr = AW'($urandom_range(0, DEPTH-1));
        for (int k = 0; k < n; k++) begin
            dw = model_pick(1'b1, 1'b1);
            exp = model_access(dw ? d_addr : i_addr, 1'b0, '0);
            run3(o);
            got = dw ? o.d_rdata : o.i_rdata;
            other = dw ? o.i_rdata : o.d_rdata;
            checks++;
            if ({o.d_ack, o.i_ack} !== {dw, !dw}) begin
                failures++; $display("FAIL contend_winner k=%0d got=%b exp=%b", k, {o.d_ack, o.i_ack}, {dw, !dw});
            end
            checks++;
            if (got !== exp || other !== '0 || o.early_ack || o.stray_rdata) begin
                failures++; $display("FAIL contend_rdata k=%0d got=%h exp=%h", k, got, exp);
            end
            seq = {seq[8:0], o.d_ack};
        end
        i_req = 1'b0; d_req = 1'b0;
        checks++;
        if (seq !== pat) begin failures++; $display("FAIL contend_order got=%b exp=%b", seq, pat); end
        checks++;
        if (both_ack !== 1'b0) begin failures++; $display("FAIL contend_both_ack got=1 exp=0"); end
    endtask

    task automatic test_halt();
        obs_t o;
        logic [DW-1:0] exp;
        logic bad;
        i_req = 1'b1; i_addr = AW'($urandom_range(0, DEPTH-1)); d_req = 1'b0;
        void'(model_pick(1'b1, 1'b0));
        exp = model_access(i_addr, 1'b0, '0);
        @(posedge clk1); @(negedge clk1);
        checks++;
        if (busy !== 1'b1 || owner !== 1'b0) begin failures++; $display("FAIL halt_grant got=%b%b exp=10", busy, owner); end
        halt = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = AW'($urandom_range(0, DEPTH-1));
        @(posedge clk1); @(negedge clk1);
        @(posedge clk1); @(negedge clk1);
        checks++;
        if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== exp) begin
            failures++; $display("FAIL halt_inflight got=%b/%h exp=1/%h", i_ack, i_rdata, exp);
        end
        i_req = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(posedge clk1); @(negedge clk1);
            bad = bad | busy | m_en | i_ack | d_ack;
        end
        checks++;
        if (bad !== 1'b0) begin failures++; $display("FAIL halt_blocks got=%b exp=0", bad); end
        halt = 1'b0;
        void'(model_pick(1'b0, 1'b1));
        exp = model_access(d_addr, 1'b0, '0);
        run3(o);
        d_req = 1'b0;
        checks++;
        if ({o.busy1, o.owner1, o.m_en1, o.d_ack} !== 4'b1111 || o.d_rdata !== exp) begin
            failures++; $display("FAIL halt_release got=%b/%h exp=1111/%h", {o.busy1, o.owner1, o.m_en1, o.d_ack}, o.d_rdata, exp);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic [DW-1:0] old;
        logic bad;
        test_contention(2, 10'b0000000011);
        old = ref_mem[3];
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'd3; d_wdata = ~old;
        @(posedge clk1); @(negedge clk1);
        checks++;
        if (m_en !== 1'b1 || m_we !== 1'b1) begin failures++; $display("FAIL rstmid_issue got=%b%b exp=11", m_en, m_we); end
        rst = 1'b1;
        @(posedge clk1); @(negedge clk1);
        rst = 1'b0; d_req = 1'b0;
        starve_ref = 0;
        checks++;
        if ({busy, m_en, i_ack, d_ack} !== 4'b0) begin
            failures++; $display("FAIL rstmid_abort got=%b exp=0000", {busy, m_en, i_ack, d_ack});
        end
        bad = 1'b0;
        repeat (3) begin
            @(posedge clk1); @(negedge clk1);
            bad = bad | i_ack | d_ack | busy;
        end
        checks++;
        if (bad !== 1'b0) begin failures++; $display("FAIL rstmid_noack got=%b exp=0", bad); end
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'd3;
        void'(model_pick(1'b0, 1'b1));
        void'(model_access(8'd3, 1'b0, '0));
        run3(o);
        d_req = 1'b0;
        checks++;
        if (o.d_rdata !== old) begin failures++; $display("FAIL rstmid_mem got=%h exp=%h", o.d_rdata, old); end
        test_contention(5, 10'b0000011110);
    endtask

    task automatic test_random();
        obs_t o;
        bit ip, dp, dwe, dw, we, inr;
        logic [AW-1:0] ia, da, a;
        logic [DW-1:0] dwd, exp, got, other;
        ip = 0; dp = 0; ia = '0; da = '0; dwe = 0; dwd = '0;
        for (int it = 0; it < 40; it++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; ia = AW'($urandom_range(0, DEPTH+3)); end
            if (!dp && ($urandom_range(0, 1) == 1 || !ip)) begin
                dp = 1; dwe = 1'($urandom_range(0, 1)); da = AW'($urandom_range(0, DEPTH+3)); dwd = $urandom;
            end
            i_req = ip; i_addr = ia; d_req = dp; d_we = dwe; d_addr = da; d_wdata = dwd;
            dw = model_pick(ip, dp);
            a = dw ? da : ia;
            we = dw && dwe;
            inr = (int'(a) < DEPTH);
            exp = model_access(a, we, dwd);
            run3(o);
            got = dw ? o.d_rdata : o.i_rdata;
            other = dw ? o.i_rdata : o.d_rdata;
            checks++;
            if ({o.d_ack, o.i_ack} !== {dw, !dw}) begin
                failures++; $display("FAIL rand_winner it=%0d got=%b exp=%b", it, {o.d_ack, o.i_ack}, {dw, !dw});
            end
            checks++;
            if ({o.busy1, o.owner1, o.m_en1, o.m_we1} !== {1'b1, dw, inr, inr && we} || o.m_addr1 !== a) begin
                failures++; $display("FAIL rand_issue it=%0d got=%b/%0h exp=%b/%0h", it,
                    {o.busy1, o.owner1, o.m_en1, o.m_we1}, o.m_addr1, {1'b1, dw, inr, inr && we}, a);
            end
            checks++;
            if (got !== exp || other !== '0 || o.err !== !inr || o.early_ack || o.stray_rdata) begin
                failures++; $display("FAIL rand_resp it=%0d got=%h err=%b exp=%h err=%b", it, got, o.err, exp, !inr);
            end
            if (dw) dp = 0; else ip = 0;
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (4) @(posedge clk1);
        @(negedge clk1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
        ref_mem[5] = 32'h2801000a;
        preload = 1'b1;
        @(posedge clk1); @(negedge clk1);
        preload = 1'b0;
        test_reset();
        test_store_load();
        test_out_of_range();
        test_latch();
        test_contention(10, 10'b1111011110);
        test_halt();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
